// File: rtl/pwm_breath_pkg.sv
// Shared definitions for the breathing-LED PWM: counter width, FSM encoding, duty helpers.
// The optional BREATH_GAMMA_EN build uses gamma_duty() for the compare threshold.
package pwm_breath_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_e;

    // Sum is formed 9 bits wide so the ceiling clamp sees the true value
    function automatic logic [7:0] duty_up(input logic [7:0] d,
                                           input logic [7:0] step,
                                           input logic [7:0] ceil);
        logic [8:0] sum;
        sum = {1'b0, d} + {1'b0, step};
        return (sum > {1'b0, ceil}) ? ceil : sum[7:0];
    endfunction

    function automatic logic [7:0] duty_down(input logic [7:0] d,
                                             input logic [7:0] step);
        return (d > step) ? (d - step) : 8'd0;
    endfunction

    function automatic logic [7:0] gamma_duty(input logic [7:0] d);
        logic [15:0] prod;
        prod = 16'(d) * 16'(d);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/wrap_detect.sv
// Detects the 255->0 wrap of the upstream free-running counter.
// wrap_int is combinational for same-cycle consumers; wrap is its registered copy.
module wrap_detect
    import pwm_breath_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    output logic             wrap_int,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt_d1;
    logic             r_wrap;

    // Only a genuine FF->00 step counts; any other jump into zero is ignored
    assign wrap_int = (r_cnt_d1 == {CNT_W{1'b1}}) && (cnt == '0);
    assign wrap     = r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_d1 <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_cnt_d1 <= cnt;
            r_wrap   <= wrap_int;
        end
    end

endmodule

// File: rtl/pwm_breath.sv
// Breathing-LED PWM: compares the upstream count with a duty that ramps, holds, falls, holds.
// Duty/state change only on counter wrap. Define BREATH_GAMMA_EN to square the compare threshold.
module pwm_breath
    import pwm_breath_pkg::*;
#(
    parameter int STEP         = 8,
    parameter int STEP_PERIODS = 1,
    parameter int HOLD_PERIODS = 16,
    parameter int MAX_DUTY     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    output logic             pwm_out,
    output logic [7:0]       duty,
    output logic             wrap,
    output logic [2:0]       state_o
);

    localparam logic [7:0]  STEP_B    = 8'(STEP);
    localparam logic [7:0]  MAX_B     = 8'(MAX_DUTY);
    localparam logic [15:0] PER_LAST  = 16'(STEP_PERIODS - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_PERIODS - 1);

    state_e      r_state, w_nxt_state;
    logic [7:0]  r_duty, w_nxt_duty;
    logic [15:0] r_per, w_nxt_per;
    logic [15:0] r_hold, w_nxt_hold;
    logic        r_pwm, w_nxt_pwm;
    logic        w_wrap_int;
    logic        w_upd;
    logic [7:0]  w_up, w_dn, w_duty_eff;

    wrap_detect u_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt      (cnt),
        .wrap_int (w_wrap_int),
        .wrap     (wrap)
    );

`ifdef BREATH_GAMMA_EN
    assign w_duty_eff = gamma_duty(r_duty);
`else
    assign w_duty_eff = r_duty;
`endif

    assign w_upd = (r_per == PER_LAST);
    assign w_up  = duty_up(r_duty, STEP_B, MAX_B);
    assign w_dn  = duty_down(r_duty, STEP_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_duty  <= 8'd0;
            r_per   <= 16'd0;
            r_hold  <= 16'd0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_duty  <= w_nxt_duty;
            r_per   <= w_nxt_per;
            r_hold  <= w_nxt_hold;
            r_pwm   <= w_nxt_pwm;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_duty  = r_duty;
        w_nxt_per   = r_per;
        w_nxt_hold  = r_hold;
        // Gating with en makes the output drop on the cycle after disable
        w_nxt_pwm   = en && (r_state != ST_IDLE) && (cnt < w_duty_eff);

        if (!en) begin
            w_nxt_state = ST_IDLE;
            w_nxt_duty  = 8'd0;
            w_nxt_per   = 16'd0;
            w_nxt_hold  = 16'd0;
        end else if (w_wrap_int) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_RISE;
                    w_nxt_per   = 16'd0;
                    w_nxt_hold  = 16'd0;
                end
                ST_RISE: begin
                    if (w_upd) begin
                        w_nxt_per  = 16'd0;
                        w_nxt_duty = w_up;
                        if (w_up == MAX_B) begin
                            w_nxt_state = ST_HOLD_HI;
                            w_nxt_hold  = 16'd0;
                        end
                    end else begin
                        w_nxt_per = r_per + 16'd1;
                    end
                end
                ST_HOLD_HI: begin
                    if (r_hold == HOLD_LAST) begin
                        w_nxt_state = ST_FALL;
                        w_nxt_hold  = 16'd0;
                        w_nxt_per   = 16'd0;
                    end else begin
                        w_nxt_hold = r_hold + 16'd1;
                    end
                end
                ST_FALL: begin
                    if (w_upd) begin
                        w_nxt_per  = 16'd0;
                        w_nxt_duty = w_dn;
                        if (w_dn == 8'd0) begin
                            w_nxt_state = ST_HOLD_LO;
                            w_nxt_hold  = 16'd0;
                        end
                    end else begin
                        w_nxt_per = r_per + 16'd1;
                    end
                end
                ST_HOLD_LO: begin
                    if (r_hold == HOLD_LAST) begin
                        w_nxt_state = ST_RISE;
                        w_nxt_hold  = 16'd0;
                        w_nxt_per   = 16'd0;
                    end else begin
                        w_nxt_hold = r_hold + 16'd1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_duty  = 8'd0;
                end
            endcase
        end
    end

    assign pwm_out = r_pwm;
    assign duty    = r_duty;
    assign state_o = r_state;

endmodule

// File: tb/tb_pwm_breath.sv
// Bench for pwm_breath: the expected duty/state after each wrap comes from a precomputed
// breathing sequence; PWM and wrap expectations are derived per cycle from the count.
module tb_pwm_breath;

    localparam int STEP = 8;
    localparam int HP   = 16;
    localparam int MAXD = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] cnt;
    logic       pwm_out;
    logic [7:0] duty;
    logic       wrap;
    logic [2:0] state_o;

    pwm_breath dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .en      (en),
        .pwm_out (pwm_out),
        .duty    (duty),
        .wrap    (wrap),
        .state_o (state_o)
    );

    always #10 clk = ~clk;

    // Each entry is {state, duty} expected right after the next wrap
    logic [10:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  m_d1;
    logic [7:0]  m_duty;
    logic [2:0]  m_state;
    int          win_len = 0;
    int          win_hi  = 0;

    function automatic int eff(input int d);
`ifdef BREATH_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic append_cycle();
        int d;
        d = 0;
        while (d != MAXD) begin
            d = (d + STEP > MAXD) ? MAXD : d + STEP;
            exp_q.push_back({(d == MAXD) ? 3'd2 : 3'd1, 8'(d)});
        end
        for (int i = 1; i <= HP; i++) exp_q.push_back({(i == HP) ? 3'd3 : 3'd2, 8'(MAXD)});
        while (d != 0) begin
            d = (d > STEP) ? d - STEP : 0;
            exp_q.push_back({(d == 0) ? 3'd4 : 3'd3, 8'(d)});
        end
        for (int i = 1; i <= HP; i++) exp_q.push_back({(i == HP) ? 3'd1 : 3'd4, 8'd0});
    endtask

    task automatic build_queue();
        exp_q.delete();
        exp_q.push_back({3'd1, 8'd0});
        append_cycle();
        append_cycle();
    endtask

    task automatic cyc();
        logic        w_exp, p_exp;
        logic [10:0] e;
        w_exp = rst_n && (m_d1 == 8'hFF) && (cnt == 8'h00);
        p_exp = rst_n && en && (m_state != 3'd0) && (int'(cnt) < eff(int'(m_duty)));
        if (rst_n && en && m_state != 3'd0 && m_duty == 8'd64) begin
            win_len++;
            win_hi += (p_exp ? 1 : 0);
        end
        if (!rst_n || !en) begin
            m_state = 3'd0;
            m_duty  = 8'd0;
        end else if (w_exp && exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            m_state = e[10:8];
            m_duty  = e[7:0];
        end
        m_d1 = rst_n ? cnt : 8'd0;
        @(posedge clk);
        #2;
        chk("wrap", {31'd0, wrap}, {31'd0, w_exp});
        chk("pwm_out", {31'd0, pwm_out}, {31'd0, p_exp});
        chk("duty", {24'd0, duty}, {24'd0, m_duty});
        chk("state_o", {29'd0, state_o}, {29'd0, m_state});
        cnt = cnt + 8'd1;
    endtask

    initial begin
        int   target, ofs, found, win_hi_seen;
        rst_n   = 1'b0;
        en      = 1'b0;
        cnt     = 8'($urandom_range(0, 255));
        m_d1    = 8'd0;
        m_duty  = 8'd0;
        m_state = 3'd0;

        // Reset held for 200 ns while the counter runs
        repeat (10) cyc();
        rst_n = 1'b1;

        // Disabled: wrap pulses only, with occasional non-wrap jumps in the count
        for (int i = 0; i < 600; i++) begin
            cyc();
            if ($urandom_range(0, 99) == 0) cnt = 8'($urandom_range(0, 255));
        end

        // One full breathing cycle from IDLE back into RISE
        build_queue();
        en = 1'b1;
        for (int i = 0; i < 30000 && exp_q.size() > 96; i++) cyc();
        chk("cycle_done_q", exp_q.size(), 96);
        chk("back_in_rise", {29'd0, state_o}, 32'd1);
        chk("rise_restart_duty", {24'd0, duty}, 32'd0);
        chk("pwm_width_d64", win_hi, eff(64));
        chk("window_len_d64", win_len, 256);
        win_hi_seen = win_hi;

        // Disable at a random point in the second fall
        target = $urandom_range(30, 220);
        ofs    = $urandom_range(1, 250);
        found  = 0;
        for (int i = 0; i < 25000 && found == 0; i++) begin
            cyc();
            if (m_state == 3'd3 && int'(m_duty) <= target && int'(cnt) == ofs) found = 1;
        end
        chk("fall_reached", found, 1);
        chk("in_fall_before_dis", {29'd0, state_o}, 32'd3);
        en = 1'b0;
        cyc();
        chk("dis_duty", {24'd0, duty}, 32'd0);
        chk("dis_state", {29'd0, state_o}, 32'd0);
        chk("dis_pwm", {31'd0, pwm_out}, 32'd0);
        repeat (5) cyc();

        // Re-enable, then an asynchronous reset pulse mid-ramp
        build_queue();
        en = 1'b1;
        for (int i = 0; i < 1000 && exp_q.size() > 190; i++) cyc();
        chk("reenable_wraps", exp_q.size(), 190);
        chk("reenable_duty", {24'd0, duty}, 32'd16);
        repeat ($urandom_range(3, 40)) cyc();
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_duty", {24'd0, duty}, 32'd0);
        chk("async_state", {29'd0, state_o}, 32'd0);
        chk("async_pwm", {31'd0, pwm_out}, 32'd0);
        chk("async_wrap", {31'd0, wrap}, 32'd0);
        m_state = 3'd0;
        m_duty  = 8'd0;
        m_d1    = 8'd0;
        repeat (3) cyc();
        rst_n = 1'b1;
        build_queue();
        for (int i = 0; i < 800 && exp_q.size() > 191; i++) cyc();
        chk("post_reset_wraps", exp_q.size(), 191);
        chk("post_reset_duty", {24'd0, duty}, 32'd8);
        chk("post_reset_state", {29'd0, state_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
